bram_lookup_client: RTL and testbench
=====================================

Name: bram_lookup_client

Overview:
- Upstream requester for read port 0 of the BRAM MAC table.
- Accepts label-index lookup requests from the MPLS forwarding pipeline and queues them in a small FIFO.
- Issues one BRAM read at a time, captures the returned 48-bit next-hop MAC, and presents it downstream with the caller's tag.
- Guards against a missing read response with a timeout.

Parameters:
- ADDR_WIDTH, 8, BRAM address / label index width.
- DATA_WIDTH, 48, MAC data width.
- TAG_WIDTH, 8, opaque caller tag carried alongside each lookup.
- FIFO_DEPTH_BITS, 2, request FIFO depth = 2**FIFO_DEPTH_BITS (4).
- TIMEOUT_CYCLES, 16, cycles to wait for read valid after ack; minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- lkup_vld  in  1  lookup request valid.
- lkup_addr  in  ADDR_WIDTH  table index.
- lkup_tag  in  TAG_WIDTH  caller tag.
- lkup_rdy  out  1  FIFO can accept a request.
- bram_read_req  out  1  read request to BRAM arbiter port 0.
- bram_read_add  out  ADDR_WIDTH  read address.
- br_read_ack  in  1  arbiter accepted the request.
- br_read_valid  in  1  read data valid.
- mac_add_in  in  DATA_WIDTH  read data.
- res_vld  out  1  result valid.
- res_mac  out  DATA_WIDTH  looked-up MAC.
- res_tag  out  TAG_WIDTH  tag of the lookup.
- res_err  out  1  lookup timed out; res_mac is 0.
- res_rdy  in  1  consumer accepts result.
- stat_lookups  out  32  completed-lookup count.
- stat_timeouts  out  32  timeout count.

Behaviour:
- Reset values: all outputs 0, lkup_rdy 0 while reset is asserted; FIFO empty; FSM in IDLE; counters 0.
- Reset is asynchronous: bram_read_req drops immediately, and any in-flight lookup is discarded.
- FIFO:
  - lkup_rdy = !full.
  - Push when lkup_vld && lkup_rdy; no bypass path.
  - Pointers wrap modulo depth; a push and a pop in the same cycle are both performed.
- FSM states: IDLE, REQ, WAIT_VALID, OUT.
- IDLE:
  - If the FIFO is non-empty: pop, register addr/tag, go to REQ.
  - bram_read_req rises the cycle after the pop.
- REQ:
  - bram_read_req = 1 and bram_read_add is held stable until br_read_ack is sampled high.
  - On ack, deassert req the next cycle, clear the timeout counter, go to WAIT_VALID.
  - If br_read_valid is high in the same cycle as ack, capture mac_add_in and go directly to OUT.
  - br_read_valid while ack has not yet been seen is ignored.
  - No timeout in REQ; the arbiter guarantees an eventual ack.
- WAIT_VALID:
  - On br_read_valid: capture mac_add_in, set res_err = 0, go to OUT.
  - If the counter reaches TIMEOUT_CYCLES-1 without valid: res_mac = 0, res_err = 1, go to OUT.
  - Stray br_read_valid in IDLE/REQ(pre-ack)/OUT is ignored.
- OUT:
  - res_vld = 1; res_mac/res_tag/res_err are held stable until res_rdy.
  - On res_vld && res_rdy: go to IDLE, and the next FIFO pop occurs in that same IDLE cycle.
- Minimum latency, with ack in the first REQ cycle and valid one cycle later: push cycle 0, req cycle 2, valid cycle 3, res_vld cycle 4.
- Throughput: one lookup in flight; the FIFO absorbs bursts.
- Counters increment on each res handshake: stat_lookups always; stat_timeouts when res_err = 1. Both saturate at 32'hFFFFFFFF.

Optional Feature:
- Macro BRAM_LOOKUP_STATS_EN.
- Defined: stat_lookups and stat_timeouts are implemented as described.
- Not defined: both ports are tied to 0 and no counter flops are synthesized; all other behaviour is unchanged.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=2'd0, REQ=2'd1, WAIT_VALID=2'd2, OUT=2'd3);
  - the default widths ADDR_WIDTH/DATA_WIDTH/TAG_WIDTH;
  - the counter saturation constant.
- One sub-module, lookup_req_fifo: a generic synchronous FIFO, parameterised by width (ADDR_WIDTH+TAG_WIDTH) and depth, with full/empty flags.

Test Plan:
- Single lookup: push addr 8'h05 tag 8'h11; ack on the first REQ cycle, valid next cycle with 48'h0011_2233_4455 -> res_vld at cycle 4, res_mac 48'h001122334455, res_tag 8'h11, res_err 0, stat_lookups = 1.
- Ack delayed 5 cycles -> bram_read_req stays high and bram_read_add stays 8'h05 for 6 cycles; req drops the cycle after ack.
- Timeout: ack given, valid never given -> res_vld with res_mac 0, res_err 1, TIMEOUT_CYCLES (16) cycles after the ack cycle; stat_timeouts = 1; a valid pulse injected afterwards is ignored.
- Backpressure/full: hold res_rdy = 0 and push 6 requests -> 1 in flight plus 4 queued; lkup_rdy goes 0 after the 5th accept. Results then return in order, tags 0..4, with outputs stable while stalled.
- Ack and valid in the same cycle -> a single result captured, no duplicate; the next request issues only after the res handshake.
- Reset asserted (reset = 0) while in WAIT_VALID with 2 entries queued -> bram_read_req and res_vld are 0 immediately and lkup_rdy is 0. After release, the FIFO is empty and no result appears.

Source files
------------

// File: rtl/bram_lookup_client_pkg.sv
// ----------------------------------------------------------------------------
// bram_lookup_client_pkg
//
// Shared definitions for the BRAM MAC-table lookup client:
//   - state_t          : lookup FSM encoding (IDLE/REQ/WAIT_VALID/OUT)
//   - DEF_*_WIDTH      : default address / data / tag widths
//   - STAT_SAT         : saturation value of the 32-bit statistics counters
//   - sat_inc()        : saturating increment used by the statistics counters
// ----------------------------------------------------------------------------
package bram_lookup_client_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQ        = 2'd1,
        WAIT_VALID = 2'd2,
        OUT        = 2'd3
    } state_t;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 48;
    localparam int DEF_TAG_WIDTH  = 8;

    localparam logic [31:0] STAT_SAT = 32'hFFFF_FFFF;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == STAT_SAT) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/lookup_req_fifo.sv
// ----------------------------------------------------------------------------
// lookup_req_fifo
//
// Generic synchronous FIFO holding queued lookup requests.
// Depth is 2**DEPTH_BITS; read data is the current head (show-ahead), so the
// consumer registers it in the same cycle it pops.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset (empties the FIFO)
//   push       in   write push_data (ignored when full)
//   push_data  in   WIDTH-bit entry
//   pop        in   drop the head entry (ignored when empty)
//   pop_data   out  head entry
//   full       out  no free entries
//   empty      out  no valid entries
// ----------------------------------------------------------------------------
module lookup_req_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [DEPTH_BITS:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS:0]   rd_ptr_q, rd_ptr_d;
    logic                  do_push;
    logic                  do_pop;
    logic [WIDTH-1:0]      mem_q [DEPTH];

    always_comb begin
        full     = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
                   (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{DEPTH_BITS{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{DEPTH_BITS{1'b0}}, do_pop};
        pop_data = mem_q[rd_ptr_q[DEPTH_BITS-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_q[DEPTH_BITS-1:0] == DEPTH_BITS'(gi))) begin
                mem_q[gi] <= push_data;
            end
        end
    end

endmodule

// File: rtl/bram_lookup_client.sv
// ----------------------------------------------------------------------------
// bram_lookup_client
//
// Upstream requester for read port 0 of the BRAM MAC table. Lookup requests
// (label index + caller tag) are queued in a small FIFO; one BRAM read is
// issued at a time, the returned next-hop MAC is captured and presented
// downstream with the caller's tag. A missing read response is turned into
// an error result (res_err = 1, res_mac = 0) after TIMEOUT_CYCLES.
//
// Build option: define BRAM_LOOKUP_STATS_EN to implement the saturating
// stat_lookups / stat_timeouts counters; otherwise both ports read 0.
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   lkup_vld/addr/tag    lookup request in; lkup_rdy = FIFO not full
//   bram_read_req/add    read request and address to the BRAM arbiter
//   br_read_ack          arbiter accepted the request
//   br_read_valid        read data valid, data on mac_add_in
//   res_vld/mac/tag/err  result out, held until res_rdy
//   stat_lookups         completed lookups (saturating)
//   stat_timeouts        timed-out lookups (saturating)
// ----------------------------------------------------------------------------
module bram_lookup_client
    import bram_lookup_client_pkg::*;
#(
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH       = DEF_TAG_WIDTH,
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lkup_vld,
    input  logic [ADDR_WIDTH-1:0] lkup_addr,
    input  logic [TAG_WIDTH-1:0]  lkup_tag,
    output logic                  lkup_rdy,
    output logic                  bram_read_req,
    output logic [ADDR_WIDTH-1:0] bram_read_add,
    input  logic                  br_read_ack,
    input  logic                  br_read_valid,
    input  logic [DATA_WIDTH-1:0] mac_add_in,
    output logic                  res_vld,
    output logic [DATA_WIDTH-1:0] res_mac,
    output logic [TAG_WIDTH-1:0]  res_tag,
    output logic                  res_err,
    input  logic                  res_rdy,
    output logic [31:0]           stat_lookups,
    output logic [31:0]           stat_timeouts
);

    localparam int ENTRY_W = ADDR_WIDTH + TAG_WIDTH;
    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [DATA_WIDTH-1:0] mac_q, mac_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic [ENTRY_W-1:0]    fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;

    // ------------------------------------------------------------------
    // Request FIFO. lkup_rdy is forced low while reset is held so nothing
    // is offered as accepted during reset.
    // ------------------------------------------------------------------
    assign lkup_rdy  = reset && !fifo_full;
    assign fifo_push = lkup_vld && lkup_rdy;

    lookup_req_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (fifo_push),
        .push_data ({lkup_addr, lkup_tag}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Lookup FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tag_d      = tag_q;
        mac_d      = mac_q;
        err_d      = err_q;
        wait_cnt_d = wait_cnt_q;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop        = 1'b1;
                    {addr_d, tag_d} = fifo_rd_data;
                    state_d         = REQ;
                end
            end

            REQ: begin
                // Read data is only meaningful once the request is accepted;
                // valid seen together with ack belongs to this request.
                if (br_read_ack) begin
                    wait_cnt_d = '0;
                    if (br_read_valid) begin
                        mac_d   = mac_add_in;
                        err_d   = 1'b0;
                        state_d = OUT;
                    end else begin
                        state_d = WAIT_VALID;
                    end
                end
            end

            WAIT_VALID: begin
                // The counter steps once per waiting cycle; reaching
                // TIMEOUT_CYCLES-1 puts the result out TIMEOUT_CYCLES
                // cycles after the ack cycle.
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
                if (br_read_valid) begin
                    mac_d   = mac_add_in;
                    err_d   = 1'b0;
                    state_d = OUT;
                end else if (wait_cnt_d == CNT_LAST) begin
                    mac_d   = '0;
                    err_d   = 1'b1;
                    state_d = OUT;
                end
            end

            OUT: begin
                if (res_rdy) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            tag_q      <= '0;
            mac_q      <= '0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tag_q      <= tag_d;
            mac_q      <= mac_d;
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Outputs decode straight from registered state, so an asynchronous
    // reset drops the request and result strobes immediately.
    assign bram_read_req = (state_q == REQ);
    assign bram_read_add = addr_q;
    assign res_vld       = (state_q == OUT);
    assign res_mac       = mac_q;
    assign res_tag       = tag_q;
    assign res_err       = err_q;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BRAM_LOOKUP_STATS_EN
    logic [31:0] stat_lookups_q, stat_lookups_d;
    logic [31:0] stat_timeouts_q, stat_timeouts_d;
    logic        res_done;

    always_comb begin
        res_done        = (state_q == OUT) && res_rdy;
        stat_lookups_d  = stat_lookups_q;
        stat_timeouts_d = stat_timeouts_q;
        if (res_done) begin
            stat_lookups_d = sat_inc(stat_lookups_q);
            if (err_q) begin
                stat_timeouts_d = sat_inc(stat_timeouts_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_lookups_q  <= '0;
            stat_timeouts_q <= '0;
        end else begin
            stat_lookups_q  <= stat_lookups_d;
            stat_timeouts_q <= stat_timeouts_d;
        end
    end

    assign stat_lookups  = stat_lookups_q;
    assign stat_timeouts = stat_timeouts_q;
`else
    assign stat_lookups  = 32'd0;
    assign stat_timeouts = 32'd0;
`endif

endmodule

// File: tb/tb_bram_lookup_client.sv
// ----------------------------------------------------------------------------
// tb_bram_lookup_client
//
// Directed scenarios for bram_lookup_client. Expected results are queued when
// a request is driven and popped when the DUT presents a result. Inputs change
// and outputs are sampled 1 time unit after the rising clock edge.
// ----------------------------------------------------------------------------
module tb_bram_lookup_client;

    logic        clk = 1'b0;
    logic        reset;
    logic        lkup_vld;
    logic [7:0]  lkup_addr;
    logic [7:0]  lkup_tag;
    logic        lkup_rdy;
    logic        bram_read_req;
    logic [7:0]  bram_read_add;
    logic        br_read_ack;
    logic        br_read_valid;
    logic [47:0] mac_add_in;
    logic        res_vld;
    logic [47:0] res_mac;
    logic [7:0]  res_tag;
    logic        res_err;
    logic        res_rdy;
    logic [31:0] stat_lookups;
    logic [31:0] stat_timeouts;

    always #5 clk = ~clk;

    bram_lookup_client #(
        .ADDR_WIDTH      (8),
        .DATA_WIDTH      (48),
        .TAG_WIDTH       (8),
        .FIFO_DEPTH_BITS (2),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .lkup_vld      (lkup_vld),
        .lkup_addr     (lkup_addr),
        .lkup_tag      (lkup_tag),
        .lkup_rdy      (lkup_rdy),
        .bram_read_req (bram_read_req),
        .bram_read_add (bram_read_add),
        .br_read_ack   (br_read_ack),
        .br_read_valid (br_read_valid),
        .mac_add_in    (mac_add_in),
        .res_vld       (res_vld),
        .res_mac       (res_mac),
        .res_tag       (res_tag),
        .res_err       (res_err),
        .res_rdy       (res_rdy),
        .stat_lookups  (stat_lookups),
        .stat_timeouts (stat_timeouts)
    );

    typedef struct {
        logic [47:0] mac;
        logic [7:0]  tag;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_lookups  = 0;
    int   model_timeouts = 0;

    // Table contents as seen by the bench's BRAM model.
    function automatic logic [47:0] mac_of(input logic [7:0] a);
        return {32'hC0FF_EE00, 8'h5A, a};
    endfunction

    function automatic logic [31:0] stat_exp(input int n);
`ifdef BRAM_LOOKUP_STATS_EN
        return 32'(n);
`else
        return 32'd0 & 32'(n);
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [47:0] mac, input logic [7:0] tag, input logic err);
        exp_t e;
        e.mac = mac;
        e.tag = tag;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs;
        lkup_vld      = 1'b0;
        lkup_addr     = 8'h00;
        lkup_tag      = 8'h00;
        br_read_ack   = 1'b0;
        br_read_valid = 1'b0;
        mac_add_in    = 48'h0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        reset   = 1'b0;
        res_rdy = 1'b1;
        clear_inputs();
        repeat (3) tick();
        n_cmp++;
        if (lkup_rdy !== 1'b0) begin
            n_bad++; $display("FAIL reset_lkup_rdy: got %b expected 0", lkup_rdy);
        end
        n_cmp++;
        if ({bram_read_req, res_vld, res_err} !== 3'b000) begin
            n_bad++; $display("FAIL reset_strobes: got req=%b vld=%b err=%b expected 0", bram_read_req, res_vld, res_err);
        end
        n_cmp++;
        if ({res_mac, res_tag, bram_read_add} !== 64'h0) begin
            n_bad++; $display("FAIL reset_data: got mac=%h tag=%h add=%h expected 0", res_mac, res_tag, bram_read_add);
        end
        n_cmp++;
        if ({stat_lookups, stat_timeouts} !== 64'h0) begin
            n_bad++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_lookups, stat_timeouts);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (lkup_rdy !== 1'b1) begin
            n_bad++; $display("FAIL post_reset_lkup_rdy: got %b expected 1", lkup_rdy);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single;
        exp_t e;
        // cycle 0: push
        lkup_vld = 1'b1; lkup_addr = 8'h05; lkup_tag = 8'h11;
        sb_push(48'h0011_2233_4455, 8'h11, 1'b0);
        tick();                                   // cycle 1
        lkup_vld = 1'b0;
        n_cmp++;
        if (bram_read_req !== 1'b0) begin
            n_bad++; $display("FAIL single_req_c1: got %b expected 0", bram_read_req);
        end
        tick();                                   // cycle 2
        n_cmp++;
        if ({bram_read_req, bram_read_add} !== {1'b1, 8'h05}) begin
            n_bad++; $display("FAIL single_req_c2: got req=%b add=%h expected 1/05", bram_read_req, bram_read_add);
        end
        br_read_ack = 1'b1;
        tick();                                   // cycle 3
        br_read_ack = 1'b0;
        n_cmp++;
        if ({bram_read_req, res_vld} !== 2'b00) begin
            n_bad++; $display("FAIL single_c3: got req=%b vld=%b expected 0/0", bram_read_req, res_vld);
        end
        br_read_valid = 1'b1; mac_add_in = 48'h0011_2233_4455;
        tick();                                   // cycle 4
        br_read_valid = 1'b0; mac_add_in = 48'hFFFF_0000_FFFF;
        n_cmp++;
        if (res_vld !== 1'b1) begin
            n_bad++; $display("FAIL single_vld_c4: got %b expected 1", res_vld);
        end else begin
            e = exp_q.pop_front();
            $display("txn single: tag=%h mac=%h err=%b", res_tag, res_mac, res_err);
            n_cmp++;
            if ({res_mac, res_tag, res_err} !== {e.mac, e.tag, e.err}) begin
                n_bad++; $display("FAIL single_result: got %h/%h/%b expected %h/%h/%b", res_mac, res_tag, res_err, e.mac, e.tag, e.err);
            end
            model_lookups++;
        end
        tick();
        n_cmp++;
        if ({res_vld, stat_lookups} !== {1'b0, stat_exp(model_lookups)}) begin
            n_bad++; $display("FAIL single_after: got vld=%b lookups=%0d expected 0/%0d", res_vld, stat_lookups, stat_exp(model_lookups));
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_ack_delay;
        exp_t e;
        lkup_vld = 1'b1; lkup_addr = 8'h05; lkup_tag = 8'h22;
        sb_push(48'h0A0B_0C0D_0E0F, 8'h22, 1'b0);
        tick();
        lkup_vld = 1'b0;
        tick();                                   // first REQ cycle
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if ({bram_read_req, bram_read_add} !== {1'b1, 8'h05}) begin
                n_bad++; $display("FAIL ack_delay_hold%0d: got req=%b add=%h expected 1/05", i, bram_read_req, bram_read_add);
            end
            br_read_valid = (i == 2);             // pre-ack valid must be ignored
            mac_add_in    = 48'hBAD0_BAD0_BAD0;
            br_read_ack   = (i == 5);
            tick();
        end
        br_read_ack = 1'b0;
        n_cmp++;
        if (bram_read_req !== 1'b0) begin
            n_bad++; $display("FAIL ack_delay_drop: got %b expected 0", bram_read_req);
        end
        br_read_valid = 1'b1; mac_add_in = 48'h0A0B_0C0D_0E0F;
        tick();
        br_read_valid = 1'b0;
        n_cmp++;
        if (res_vld !== 1'b1) begin
            n_bad++; $display("FAIL ack_delay_vld: got %b expected 1", res_vld);
        end else begin
            e = exp_q.pop_front();
            $display("txn ack_delay: tag=%h mac=%h err=%b", res_tag, res_mac, res_err);
            n_cmp++;
            if ({res_mac, res_tag, res_err} !== {e.mac, e.tag, e.err}) begin
                n_bad++; $display("FAIL ack_delay_result: got %h/%h/%b expected %h/%h/%b", res_mac, res_tag, res_err, e.mac, e.tag, e.err);
            end
            model_lookups++;
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_timeout;
        exp_t e;
        logic seen;
        lkup_vld = 1'b1; lkup_addr = 8'h07; lkup_tag = 8'h33;
        sb_push(48'h0, 8'h33, 1'b1);
        tick();
        lkup_vld = 1'b0;
        tick();                                   // REQ
        br_read_ack = 1'b1;                       // ack cycle A
        tick();                                   // A+1
        br_read_ack = 1'b0;
        for (int k = 1; k < 16; k++) begin
            n_cmp++;
            if (res_vld !== 1'b0) begin
                n_bad++; $display("FAIL timeout_early_A+%0d: got vld=%b expected 0", k, res_vld);
            end
            tick();
        end
        n_cmp++;                                  // A+16
        if (res_vld !== 1'b1) begin
            n_bad++; $display("FAIL timeout_vld: got %b expected 1", res_vld);
        end else begin
            e = exp_q.pop_front();
            $display("txn timeout: tag=%h mac=%h err=%b", res_tag, res_mac, res_err);
            n_cmp++;
            if ({res_mac, res_tag, res_err} !== {e.mac, e.tag, e.err}) begin
                n_bad++; $display("FAIL timeout_result: got %h/%h/%b expected %h/%h/%b", res_mac, res_tag, res_err, e.mac, e.tag, e.err);
            end
            model_lookups++;
            model_timeouts++;
        end
        tick();
        br_read_valid = 1'b1; mac_add_in = 48'h1234_5678_9ABC;   // stray pulse
        tick();
        br_read_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (res_vld || bram_read_req) seen = 1'b1;
            tick();
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++; $display("FAIL timeout_stray_valid: got activity=%b expected 0", seen);
        end
        n_cmp++;
        if ({stat_lookups, stat_timeouts} !== {stat_exp(model_lookups), stat_exp(model_timeouts)}) begin
            n_bad++; $display("FAIL timeout_stats: got %0d/%0d expected %0d/%0d", stat_lookups, stat_timeouts, stat_exp(model_lookups), stat_exp(model_timeouts));
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure;
        exp_t        e;
        int          idx;
        int          got;
        logic        rdy_now;
        logic        ack_prev;
        logic [47:0] snap_mac;
        logic [7:0]  snap_tag;
        res_rdy  = 1'b0;
        idx      = 0;
        ack_prev = 1'b0;
        for (int c = 0; c < 25; c++) begin
            lkup_vld  = (idx < 6);
            lkup_addr = 8'h40 + 8'(idx);
            lkup_tag  = 8'(idx);
            rdy_now   = lkup_rdy;
            br_read_ack   = bram_read_req;
            br_read_valid = ack_prev;
            mac_add_in    = mac_of(bram_read_add);
            ack_prev      = br_read_ack;
            tick();
            if (lkup_vld && rdy_now) begin
                sb_push(mac_of(8'h40 + 8'(idx)), 8'(idx), 1'b0);
                idx++;
                if (idx == 5) begin
                    n_cmp++;
                    if (lkup_rdy !== 1'b0) begin
                        n_bad++; $display("FAIL bp_full_after_5th: got lkup_rdy=%b expected 0", lkup_rdy);
                    end
                end
            end
        end
        clear_inputs();
        n_cmp++;
        if (idx !== 5) begin
            n_bad++; $display("FAIL bp_accepted: got %0d expected 5", idx);
        end
        n_cmp++;
        if ({res_vld, lkup_rdy, bram_read_req} !== 3'b100) begin
            n_bad++; $display("FAIL bp_stalled: got vld=%b rdy=%b req=%b expected 1/0/0", res_vld, lkup_rdy, bram_read_req);
        end
        snap_mac = res_mac;
        snap_tag = res_tag;
        for (int c = 0; c < 4; c++) begin
            br_read_valid = (c == 1);
            mac_add_in    = 48'hDEAD_DEAD_DEAD;
            tick();
            n_cmp++;
            if ({res_vld, res_mac, res_tag, bram_read_req} !== {1'b1, snap_mac, snap_tag, 1'b0}) begin
                n_bad++; $display("FAIL bp_stable%0d: got vld=%b mac=%h tag=%h req=%b expected 1/%h/%h/0", c, res_vld, res_mac, res_tag, bram_read_req, snap_mac, snap_tag);
            end
        end
        clear_inputs();
        res_rdy  = 1'b1;
        got      = 0;
        ack_prev = 1'b0;
        for (int c = 0; c < 80 && got < 5; c++) begin
            if (res_vld) begin
                e = exp_q.pop_front();
                $display("txn backpressure: tag=%h mac=%h err=%b", res_tag, res_mac, res_err);
                n_cmp++;
                if ({res_mac, res_tag, res_err} !== {e.mac, e.tag, e.err}) begin
                    n_bad++; $display("FAIL bp_result%0d: got %h/%h/%b expected %h/%h/%b", got, res_mac, res_tag, res_err, e.mac, e.tag, e.err);
                end
                got++;
                model_lookups++;
            end
            br_read_ack   = bram_read_req;
            br_read_valid = ack_prev;
            mac_add_in    = mac_of(bram_read_add);
            ack_prev      = br_read_ack;
            tick();
        end
        clear_inputs();
        n_cmp++;
        if (got !== 5) begin
            n_bad++; $display("FAIL bp_drain_count: got %0d expected 5 results within budget", got);
        end
        tick();
        n_cmp++;
        if (stat_lookups !== stat_exp(model_lookups)) begin
            n_bad++; $display("FAIL bp_stats: got %0d expected %0d", stat_lookups, stat_exp(model_lookups));
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_ack_valid_same;
        exp_t e;
        logic seen;
        res_rdy = 1'b0;
        lkup_vld = 1'b1; lkup_addr = 8'h10; lkup_tag = 8'h70;
        sb_push(mac_of(8'h10), 8'h70, 1'b0);
        tick();
        lkup_addr = 8'h11; lkup_tag = 8'h71;
        sb_push(mac_of(8'h11), 8'h71, 1'b0);
        tick();                                   // REQ for tag 70
        lkup_vld = 1'b0;
        n_cmp++;
        if ({bram_read_req, bram_read_add} !== {1'b1, 8'h10}) begin
            n_bad++; $display("FAIL same_req1: got req=%b add=%h expected 1/10", bram_read_req, bram_read_add);
        end
        br_read_ack = 1'b1; br_read_valid = 1'b1; mac_add_in = mac_of(8'h10);
        tick();
        clear_inputs();
        n_cmp++;
        if (res_vld !== 1'b1) begin
            n_bad++; $display("FAIL same_vld1: got %b expected 1", res_vld);
        end else begin
            e = exp_q.pop_front();
            $display("txn ack_valid_same: tag=%h mac=%h err=%b", res_tag, res_mac, res_err);
            n_cmp++;
            if ({res_mac, res_tag, res_err} !== {e.mac, e.tag, e.err}) begin
                n_bad++; $display("FAIL same_result1: got %h/%h/%b expected %h/%h/%b", res_mac, res_tag, res_err, e.mac, e.tag, e.err);
            end
            model_lookups++;
        end
        for (int j = 0; j < 3; j++) begin
            br_read_valid = (j == 0);
            mac_add_in    = 48'hEEEE_EEEE_EEEE;
            tick();
            n_cmp++;
            if ({bram_read_req, res_vld, res_mac} !== {1'b0, 1'b1, mac_of(8'h10)}) begin
                n_bad++; $display("FAIL same_hold%0d: got req=%b vld=%b mac=%h expected 0/1/%h", j, bram_read_req, res_vld, res_mac, mac_of(8'h10));
            end
        end
        clear_inputs();
        res_rdy = 1'b1;
        tick();                                   // IDLE, pops tag 71
        n_cmp++;
        if ({res_vld, bram_read_req} !== 2'b00) begin
            n_bad++; $display("FAIL same_idle: got vld=%b req=%b expected 0/0", res_vld, bram_read_req);
        end
        tick();
        n_cmp++;
        if ({bram_read_req, bram_read_add} !== {1'b1, 8'h11}) begin
            n_bad++; $display("FAIL same_req2: got req=%b add=%h expected 1/11", bram_read_req, bram_read_add);
        end
        br_read_ack = 1'b1; br_read_valid = 1'b1; mac_add_in = mac_of(8'h11);
        tick();
        clear_inputs();
        n_cmp++;
        if (res_vld !== 1'b1) begin
            n_bad++; $display("FAIL same_vld2: got %b expected 1", res_vld);
        end else begin
            e = exp_q.pop_front();
            $display("txn ack_valid_same: tag=%h mac=%h err=%b", res_tag, res_mac, res_err);
            n_cmp++;
            if ({res_mac, res_tag, res_err} !== {e.mac, e.tag, e.err}) begin
                n_bad++; $display("FAIL same_result2: got %h/%h/%b expected %h/%h/%b", res_mac, res_tag, res_err, e.mac, e.tag, e.err);
            end
            model_lookups++;
        end
        seen = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (res_vld || bram_read_req) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++; $display("FAIL same_no_duplicate: got activity=%b expected 0", seen);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midflight;
        logic seen;
        logic ack_prev;
        res_rdy = 1'b1;
        lkup_vld = 1'b1; lkup_addr = 8'h20; lkup_tag = 8'h80;
        sb_push(mac_of(8'h20), 8'h80, 1'b0);
        tick();
        lkup_addr = 8'h21; lkup_tag = 8'h81;
        sb_push(mac_of(8'h21), 8'h81, 1'b0);
        tick();                                   // REQ for tag 80
        lkup_addr = 8'h22; lkup_tag = 8'h82;
        sb_push(mac_of(8'h22), 8'h82, 1'b0);
        br_read_ack = 1'b1;
        tick();                                   // WAIT_VALID, 2 queued
        clear_inputs();
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bram_read_req, res_vld, lkup_rdy} !== 3'b000) begin
            n_bad++; $display("FAIL rst_async: got req=%b vld=%b rdy=%b expected 0/0/0", bram_read_req, res_vld, lkup_rdy);
        end
        exp_q.delete();                           // in-flight and queued lookups are discarded
        model_lookups  = 0;
        model_timeouts = 0;
        tick();
        tick();
        reset = 1'b1;
        n_cmp++;
        if ({stat_lookups, stat_timeouts} !== {stat_exp(model_lookups), stat_exp(model_timeouts)}) begin
            n_bad++; $display("FAIL rst_stats: got %0d/%0d expected 0/0", stat_lookups, stat_timeouts);
        end
        seen     = 1'b0;
        ack_prev = 1'b0;
        for (int c = 0; c < 30; c++) begin
            br_read_ack   = bram_read_req;
            br_read_valid = ack_prev;
            mac_add_in    = mac_of(bram_read_add);
            ack_prev      = br_read_ack;
            tick();
            if (res_vld || bram_read_req) seen = 1'b1;
        end
        clear_inputs();
        n_cmp++;
        if ({seen, lkup_rdy} !== 2'b01) begin
            n_bad++; $display("FAIL rst_fifo_empty: got activity=%b rdy=%b expected 0/1", seen, lkup_rdy);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++; $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_single();
        test_ack_delay();
        test_timeout();
        test_backpressure();
        test_ack_valid_same();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
